// File: rtl/shift_pipe.sv
// Pipelined log-shifter (SLL/SRL/SRA, optional ROR) with one register per level and a global stall.
// Define SHIFT_PIPE_ROTATE_EN to build the rotate path; otherwise mode 10 returns zero.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_s,
    output logic [TAG_W-1:0]   out_tag
);

    logic stall;
    logic advance;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall;

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : lvl
            localparam int AMT   = 1 << gi;
            localparam int REM_W = SHAMT_W - gi;

            logic             src_valid;
            logic [1:0]       src_mode;
            logic             src_sign;
            logic [REM_W-1:0] src_rem;
            logic [WIDTH-1:0] src_data;
            logic [TAG_W-1:0] src_tag;
            logic [WIDTH-1:0] shifted;
            logic [WIDTH-1:0] level_data;

            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_src
                assign src_valid = in_valid;
                assign src_mode  = in_mode;
                assign src_sign  = in_b[WIDTH-1];
                assign src_rem   = in_shamt;
                assign src_data  = in_b;
                assign src_tag   = in_tag;
            end else begin : g_src
                assign src_valid = lvl[gi-1].valid_reg;
                assign src_mode  = lvl[gi-1].g_ctl.mode_reg;
                assign src_sign  = lvl[gi-1].g_ctl.sign_reg;
                assign src_rem   = lvl[gi-1].g_ctl.rem_reg;
                assign src_data  = lvl[gi-1].data_reg;
                assign src_tag   = lvl[gi-1].tag_reg;
            end

            always_comb begin
                case (src_mode)
                    2'b00:   shifted = src_data << AMT;
                    2'b01:   shifted = src_data >> AMT;
                    2'b11:   shifted = {{AMT{src_sign}}, src_data[WIDTH-1:AMT]};
`ifdef SHIFT_PIPE_ROTATE_EN
                    default: shifted = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
`else
                    default: shifted = '0;
`endif
                endcase
            end

            always_comb begin
                level_data = src_rem[0] ? shifted : src_data;
`ifndef SHIFT_PIPE_ROTATE_EN
                // Unsupported mode yields zero even when this level does not shift.
                if (src_mode == 2'b10) level_data = '0;
`endif
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    tag_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= src_valid;
                    data_reg  <= level_data;
                    tag_reg   <= src_tag;
                end
            end

            // Control only travels as far as a later level still needs it.
            if (gi < SHAMT_W - 1) begin : g_ctl
                logic [1:0]       mode_reg;
                logic             sign_reg;
                logic [REM_W-2:0] rem_reg;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        mode_reg <= '0;
                        sign_reg <= 1'b0;
                        rem_reg  <= '0;
                    end else if (advance) begin
                        mode_reg <= src_mode;
                        sign_reg <= src_sign;
                        rem_reg  <= src_rem[REM_W-1:1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = lvl[SHAMT_W-1].valid_reg;
    assign out_s     = lvl[SHAMT_W-1].data_reg;
    assign out_tag   = lvl[SHAMT_W-1].tag_reg;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: queue-based reference model with a per-cycle compare process,
// directed scenarios with literal expectations, and randomized traffic with stalls.
module tb_shift_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SW    = 5;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SW-1:0]    in_shamt = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_mode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_s;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_shamt(in_shamt),
        .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_tag(out_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] b, input int sh);
        logic [63:0] dbl;
        case (m)
            2'b00: return b << sh;
            2'b01: return b >> sh;
            2'b11: return 32'($signed(b) >>> sh);
            default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                dbl = {b, b} >> sh;
                return dbl[31:0];
`else
                dbl = '0;
                return dbl[31:0];
`endif
            end
        endcase
    endfunction

    typedef struct {
        logic [31:0] s;
        logic [3:0]  t;
        int          acc;
        int          st;
        bit          shown;
    } item_t;

    item_t q[$];
    int now = 0;
    int stall_cnt = 0;

    // Reference: each accepted request emerges LAT cycles later, delayed by one per stall cycle in between.
    initial begin
        item_t it;
        bit exp_v, exp_rdy;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
            end else begin
                exp_v = (q.size() > 0) &&
                        (q[0].shown || (q[0].acc + LAT + (stall_cnt - q[0].st) <= now));
                chk("out_valid", out_valid, exp_v);
                exp_rdy = !(exp_v && !out_ready);
                chk("in_ready", in_ready, exp_rdy);
                if (exp_v && out_valid) begin
                    chk("out_s", out_s, q[0].s);
                    chk("out_tag", out_tag, q[0].t);
                    q[0].shown = 1'b1;
                    if (out_ready) begin
                        $display("xfer tag=%0h s=%08h cycle=%0d", out_tag, out_s, now);
                        void'(q.pop_front());
                    end
                end
                if (exp_v && !out_ready) stall_cnt++;
                if (in_valid && exp_rdy) begin
                    it.s = ref_shift(in_mode, in_b, int'(in_shamt));
                    it.t = in_tag;
                    it.acc = now;
                    it.st = stall_cnt;
                    it.shown = 1'b0;
                    q.push_back(it);
                end
            end
            now++;
        end
    end

    task automatic step(input logic v, input logic [1:0] m, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] t, input logic ordy,
                        output logic acc);
        @(posedge clk);
        #1;
        in_valid = v; in_mode = m; in_b = b; in_shamt = sh; in_tag = t; out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1, acc);
    endtask

    task automatic single(input logic [1:0] m, input logic [31:0] b, input logic [4:0] sh,
                          input logic [3:0] t, input logic [31:0] want);
        logic acc;
        step(1'b1, m, b, sh, t, 1'b1, acc);
        chk("single_accept", acc, 1);
        for (int k = 1; k <= LAT; k++) begin
            step(1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1, acc);
            chk("single_latency", out_valid, (k == LAT));
        end
        chk("single_s", out_s, want);
        chk("single_tag", out_tag, t);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic [31:0] want;
        int idx;

        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_s", out_s, 0);
        chk("rst_out_tag", out_tag, 0);

        single(2'b00, 32'h0000_0001, 5'd31, 4'h5, 32'h8000_0000);
        single(2'b11, 32'h8000_0000, 5'd4, 4'h6, 32'hF800_0000);
        single(2'b01, 32'h8000_0000, 5'd4, 4'h7, 32'h0800_0000);
        single(2'b11, 32'h7000_0000, 5'd4, 4'h8, 32'h0700_0000);
`ifdef SHIFT_PIPE_ROTATE_EN
        single(2'b10, 32'h0000_00F1, 5'd4, 4'h9, 32'h1000_000F);
`else
        single(2'b10, 32'h0000_00F1, 5'd4, 4'h9, 32'h0000_0000);
`endif
        for (int m = 0; m < 4; m++) begin
            want = 32'hA5A5_5A5A;
`ifndef SHIFT_PIPE_ROTATE_EN
            if (m == 2) want = 32'h0;
`endif
            single(2'(m), 32'hA5A5_5A5A, 5'd0, 4'(m), want);
        end

        // Back-to-back tags 0..7 with a three-cycle output stall starting at cycle 6.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            step(idx < 8, 2'(idx % 4), 32'h8765_4321 + 32'(idx), 5'(3 * idx + 1), 4'(idx),
                 !(c >= 6 && c < 9), acc);
            if (c >= 6 && c < 9) chk("stall_in_ready", in_ready, 0);
            if (acc) idx++;
        end
        chk("stall_all_issued", 32'(idx), 8);
        chk("stall_drained", 32'(q.size()), 0);

        // Reset with three requests in flight, and a request offered during reset.
        step(1'b1, 2'b00, 32'h1111_1111, 5'd1, 4'hA, 1'b1, acc);
        step(1'b1, 2'b01, 32'h2222_2222, 5'd2, 4'hB, 1'b1, acc);
        step(1'b1, 2'b11, 32'h8333_3333, 5'd3, 4'hC, 1'b1, acc);
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b1; in_tag = 4'hF;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_s", out_s, 0);
        chk("midrst_out_tag", out_tag, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1, acc);
            chk("midrst_no_stale", out_valid, 0);
        end
        single(2'b00, 32'h0000_0003, 5'd2, 4'h1, 32'h0000_000C);

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] b;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), b,
                 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, acc);
        end
        idle(12);
        chk("final_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
